// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: one shared edge/center-aligned timebase, NCH compare
// channels, shadowed period/duty that switch over only at a PWM-cycle boundary.
module pwm_gen_mc #(
    parameter int CNT_W = 16,
    parameter int NCH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [NCH*CNT_W-1:0] duty,
    input  logic               load,
    input  logic [NCH-1:0]     pol,
    output logic [NCH-1:0]     pwm_out,
    output logic               period_end,
    output logic               load_ack
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    dir_t                 r_dir;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_per_act;
    logic [CNT_W-1:0]     r_per_pend;
    logic [NCH*CNT_W-1:0] r_duty_act;
    logic [NCH*CNT_W-1:0] r_duty_pend;
    logic                 r_mode_act;
    logic                 r_pend;

    logic [CNT_W-1:0]     w_per_eff;
    logic [CNT_W-1:0]     w_last;
    logic                 w_bnd;
    logic                 w_xfer;
    logic [NCH-1:0]       w_raw;

    assign w_per_eff = (r_per_act == '0) ? CNT_W'(1) : r_per_act;
    assign w_last    = w_per_eff - CNT_W'(1);
    assign w_bnd     = r_mode_act ? (r_dir == DIR_DOWN && r_cnt == '0) : (r_cnt == w_last);
    // While disabled every cycle acts as a transfer point, so loads apply immediately.
    assign w_xfer    = (!en || w_bnd) && (load || r_pend);

    always_comb begin
        w_raw = '0;
        for (int unsigned i = 0; i < NCH; i++)
            w_raw[i] = r_cnt < r_duty_act[i*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dir       <= DIR_UP;
            r_per_act   <= CNT_W'(1);
            r_per_pend  <= '0;
            r_duty_act  <= '0;
            r_duty_pend <= '0;
            r_mode_act  <= 1'b0;
            r_pend      <= 1'b0;
            pwm_out     <= '0;
            period_end  <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            load_ack <= w_xfer;
            if (w_xfer) begin
                r_per_act  <= load ? period : r_per_pend;
                r_duty_act <= load ? duty   : r_duty_pend;
                r_pend     <= 1'b0;
            end else if (load) begin
                r_per_pend  <= period;
                r_duty_pend <= duty;
                r_pend      <= 1'b1;
            end

            if (!en) begin
                r_cnt      <= '0;
                r_dir      <= DIR_UP;
                r_mode_act <= mode;
                pwm_out    <= pol;
                period_end <= 1'b0;
            end else begin
                pwm_out    <= w_raw ^ pol;
                period_end <= w_bnd;
                // Both modes restart from 0 counting up, so a mode switch here is seamless.
                if (w_bnd) begin
                    r_cnt      <= '0;
                    r_dir      <= DIR_UP;
                    r_mode_act <= mode;
                end else if (!r_mode_act) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_dir == DIR_UP) begin
                    if (r_cnt == w_last)
                        r_dir <= DIR_DOWN;
                    else
                        r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Bench for pwm_gen_mc: a cycle-position model checked every clock, plus directed
// scenarios with hand-computed literal expectations.
module tb_pwm_gen_mc;

    localparam int CNT_W = 16;
    localparam int NCH   = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 mode;
    logic [CNT_W-1:0]     period;
    logic [NCH*CNT_W-1:0] duty;
    logic                 load;
    logic [NCH-1:0]       pol;
    logic [NCH-1:0]       pwm_out;
    logic                 period_end;
    logic                 load_ack;

    int n_chk  = 0;
    int n_fail = 0;

    pwm_gen_mc #(.CNT_W(CNT_W), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .duty(duty), .load(load), .pol(pol), .pwm_out(pwm_out),
        .period_end(period_end), .load_ack(load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position k within the PWM cycle; counter value derived from k.
    bit             m_on = 1'b0;
    int             m_per, m_mode, m_k, m_pend, m_pper;
    int             m_duty[NCH];
    int             m_pduty[NCH];
    logic [NCH-1:0] e_pwm;
    logic           e_pe, e_ack;

    always @(posedge clk) begin
        int  p, len, c;
        bit  xfer;
        if (!rst_n) begin
            m_on = 1'b1; m_per = 1; m_mode = 0; m_k = 0; m_pend = 0; m_pper = 0;
            for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_pduty[i] = 0; end
            e_pwm = '0; e_pe = 1'b0; e_ack = 1'b0;
        end else begin
            xfer = 1'b0;
            if (!en) begin
                e_pwm = pol; e_pe = 1'b0; m_k = 0; m_mode = int'(mode);
                xfer = load || (m_pend != 0);
            end else begin
                p   = (m_per == 0) ? 1 : m_per;
                len = (m_mode != 0) ? 2 * p : p;
                c   = (m_mode != 0 && m_k >= p) ? (2 * p - 1 - m_k) : m_k;
                for (int i = 0; i < NCH; i++)
                    e_pwm[i] = (c < m_duty[i]) ^ pol[i];
                e_pe = (m_k == len - 1);
                if (e_pe) begin
                    m_k = 0; m_mode = int'(mode);
                    xfer = load || (m_pend != 0);
                end else begin
                    m_k++;
                end
            end
            if (xfer) begin
                m_per = load ? int'(period) : m_pper;
                for (int i = 0; i < NCH; i++)
                    m_duty[i] = load ? int'(duty[i*CNT_W +: CNT_W]) : m_pduty[i];
                m_pend = 0;
            end else if (load) begin
                m_pper = int'(period);
                for (int i = 0; i < NCH; i++) m_pduty[i] = int'(duty[i*CNT_W +: CNT_W]);
                m_pend = 1;
            end
            e_ack = xfer;
        end
        #1;
        if (m_on) begin
            n_chk += 3;
            if (pwm_out !== e_pwm) begin
                n_fail++; $display("FAIL model_pwm t=%0t got %b want %b", $time, pwm_out, e_pwm);
            end
            if (period_end !== e_pe) begin
                n_fail++; $display("FAIL model_period_end t=%0t got %b want %b", $time, period_end, e_pe);
            end
            if (load_ack !== e_ack) begin
                n_fail++; $display("FAIL model_load_ack t=%0t got %b want %b", $time, load_ack, e_ack);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int p, input int d3, input int d2, input int d1, input int d0);
        period = CNT_W'(p);
        duty   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endtask

    task automatic load_now(input int p, input int d3, input int d2, input int d1, input int d0);
        set_in(p, d3, d2, d1, d0);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit found = 1'b0;
        for (int j = 0; j < 60 && !found; j++) begin
            @(negedge clk);
            if (load_ack) found = 1'b1;
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        int h0, h1, h2, npe, nack, nall;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; pol = '0;
        period = '0; duty = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_pe", int'(period_end), 0);
        chk("reset_ack", int'(load_ack), 0);
        rst_n = 1'b1;

        // Edge mode, period 10, duties 0,3,10,12
        load_now(10, 12, 10, 3, 0);
        chk("edge_load_ack_en0", int'(load_ack), 1);
        en = 1'b1;
        h0 = 0; h1 = 0; h2 = 0; npe = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk("edge_first_pwm", int'(pwm_out), 4'b1110);
            h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
            npe += int'(period_end);
        end
        chk("edge_ch0_high", h0, 0);
        chk("edge_ch1_high", h1, 12);
        chk("edge_ch2_high", h2, 40);
        chk("edge_pe_count", npe, 4);

        // Center mode, period 8, ch0 duty 2
        en = 1'b0; mode = 1'b1;
        load_now(8, 0, 0, 0, 2);
        en = 1'b1;
        h0 = 0; npe = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 1)  chk("ctr_ch0_idx1", int'(pwm_out[0]), 1);
            if (i == 2)  chk("ctr_ch0_idx2", int'(pwm_out[0]), 0);
            if (i == 14) chk("ctr_ch0_idx14", int'(pwm_out[0]), 1);
            if (i == 15) chk("ctr_pe_idx15", int'(period_end), 1);
            h0 += int'(pwm_out[0]); npe += int'(period_end);
        end
        chk("ctr_ch0_high", h0, 8);
        chk("ctr_pe_count", npe, 2);

        // Shadow update with a double load before the boundary
        en = 1'b0; mode = 1'b0;
        load_now(10, 5, 5, 5, 5);
        en = 1'b1;
        repeat (3) @(negedge clk);
        load_now(20, 9, 9, 9, 9);
        @(negedge clk);
        load_now(20, 4, 4, 4, 4);
        chk("shadow_no_early_ack", int'(load_ack), 0);
        wait_ack("shadow_ack_seen");
        chk("shadow_ack_with_pe", int'(period_end), 1);
        h0 = 0; npe = 0; nack = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]); npe += int'(period_end); nack += int'(load_ack);
        end
        chk("shadow_ch0_high", h0, 4);
        chk("shadow_pe_count", npe, 1);
        chk("shadow_single_ack", nack, 0);

        // Bypass: load in the boundary cycle (counter 19)
        repeat (19) @(negedge clk);
        set_in(6, 2, 2, 2, 2);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bypass_ack", int'(load_ack), 1);
        chk("bypass_pe", int'(period_end), 1);
        h0 = 0; npe = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]); npe += int'(period_end);
        end
        chk("bypass_ch0_high", h0, 2);
        chk("bypass_pe_count", npe, 1);

        // Period 0 treated as 1
        load_now(0, 1, 1, 1, 1);
        wait_ack("p0_ack_seen");
        npe = 0; nall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            npe += int'(period_end); nall += int'(pwm_out == 4'b1111);
        end
        chk("p0_pe_count", npe, 10);
        chk("p0_all_high", nall, 10);

        // Idle polarity, enable start, reset with pending load
        en = 1'b0; pol = 4'b1010;
        @(negedge clk);
        chk("idle_pwm_pol", int'(pwm_out), 4'b1010);
        chk("idle_pe", int'(period_end), 0);
        load_now(10, 3, 3, 3, 3);
        en = 1'b1;
        @(negedge clk);
        chk("en_first_pwm", int'(pwm_out), 4'b0101);
        repeat (3) @(negedge clk);
        load_now(5, 1, 1, 1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_pwm", int'(pwm_out), 0);
        chk("rst_mid_ack", int'(load_ack), 0);
        rst_n = 1'b1; pol = '0;
        npe = 0; nack = 0; nall = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            npe += int'(period_end); nack += int'(load_ack); nall += int'(pwm_out == 4'b0000);
        end
        chk("post_rst_pe_count", npe, 8);
        chk("post_rst_no_ack", nack, 0);
        chk("post_rst_pwm_low", nall, 8);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_gen_mc.md
Name: pwm_gen_mc

Overview:
- Multi-channel PWM generator: one shared period counter drives NCH compare channels.
- Parametrised counter width; edge-aligned or center-aligned mode; per-channel output polarity.
- Period and duty go through a shadow register with a load handshake, so new values take effect only at a period boundary and never produce a glitch.
- Used in the DDS/PWM output stage where several phase-related PWM outputs must share a common timebase.

Parameters:
- CNT_W, 16: width of the counter, period and each duty value.
- NCH, 4: number of PWM channels.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- en, in, 1: run enable; 0 = counter parked and outputs at idle level.
- mode, in, 1: 0 = edge-aligned, 1 = center-aligned. Sampled only at a boundary or while en=0.
- period, in, CNT_W: period value to be shadowed.
- duty, in, NCH*CNT_W: per-channel high time; channel i occupies bits [i*CNT_W +: CNT_W].
- load, in, 1: single-cycle strobe that captures period and duty into the shadow registers.
- pol, in, NCH: per-channel output inversion (1 = active-low output).
- pwm_out, out, NCH: registered PWM outputs.
- period_end, out, 1: one-cycle pulse on the last cycle of each PWM cycle.
- load_ack, out, 1: one-cycle pulse when shadow values are transferred to the active registers.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - counter=0, direction=up, active period=1, active duties=0, pending flag=0, active mode=0.
  - pwm_out=0, period_end=0, load_ack=0.
- Effective period P = max(active period, 1). A period of 0 is treated as 1.
- Edge mode:
  - Counter runs 0..P-1, then wraps to 0. Cycle length is P clocks.
  - Boundary = the cycle with counter = P-1.
- Center mode:
  - Counter counts up 0..P-1, holds direction change, then counts down P-1..0. Each endpoint value appears twice.
  - Cycle length is 2P clocks.
  - Boundary = the down-count cycle with counter = 0.
  - When P=1 the counter stays at 0 and every second clock is a boundary.
- Compare: raw[i] = (counter < duty_act[i]).
  - duty=0 gives constant low.
  - duty>=P gives constant high, with no glitch.
- Output: pwm_out[i] <= raw[i] ^ pol[i], registered. pwm_out lags the counter by exactly 1 clock.
- period_end:
  - Registered, aligned with pwm_out; it is high on the clock in which the output of the boundary count is presented.
  - Never asserted while en=0.
- Load handshake:
  - load=1 captures period/duty into the pending registers and sets the pending flag.
  - A further load while pending overwrites the pending values; the last one wins and only one load_ack is issued.
  - At a boundary with the flag set: active period/duty/mode <= pending values, flag cleared, load_ack pulses on the next clock.
  - load asserted in the boundary cycle itself: the inputs are transferred directly to active at that boundary (bypass), followed by a single load_ack.
- en=0:
  - Counter forced to 0, direction up.
  - pwm_out = pol (idle level), period_end=0.
  - A load is applied to the active registers on the next clock, with load_ack.
- en 0 to 1: counting starts from 0 on the next clock. The first pwm_out sample reflects counter=0 one clock later.
- A change in the mode input between boundaries has no effect until the next transfer, a boundary, or while en=0.
- Reset mid-cycle: all state returns to reset values at that clock edge, and any pending load is discarded.
- Arithmetic: the counter is CNT_W bits. P-1 is computed in CNT_W bits; because P>=1 it never underflows. Period 2^CNT_W-1 is supported.

Test Plan:
- Edge mode: period=10, duty ch0..3 = 0,3,10,12, pol=0, en=1. Each channel repeats every 10 clks: ch0 constant 0, ch1 3 high/7 low, ch2 and ch3 constant 1. period_end pulses every 10 clks.
- Center mode: period=8, duty ch0=2. Cycle is 16 clks. ch0 high for counts 0,1 up and 1,0 down, i.e. 2 clks high at each end of the cycle. The high pulses straddle the boundary and are symmetric. period_end every 16 clks.
- Shadow update: running period=10 duty=5; load period=20 duty=4 mid-cycle. Outputs unchanged until the boundary. load_ack comes 1 clk after the boundary, and the next cycle is 20 clks with 4 high. A second load before the boundary gives only the last value and one ack.
- Boundary bypass plus period 0: load asserted exactly on the boundary cycle, so the new values apply at that boundary. Then load period=0 duty=1: output constant high in edge mode and period_end every clk.
- en/pol/reset: pol=4'b1010 with en=0 gives pwm_out=1010 and period_end=0. Raise en: the first counter=0 sample appears after 1 clk. Assert rst_n=0 mid-cycle with a load pending: pwm_out=0, there is no load_ack, and after release the active period=1 and duty=0.
